// File: rtl/trap_entry_if.sv
// Trap-entry handshake bundle: exception request/ack, pipeline flush and fetch redirect.
// master = trap controller, slave = decode/execute and fetch side.
interface trap_entry_if;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic [31:0] trap_pc;
  logic        exc_ack;
  logic        flush_req;
  logic        flush_ack;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    input  exc_valid, exc_cause, exc_tval, trap_pc, flush_ack, redirect_ready,
    output exc_ack, flush_req, redirect_valid, redirect_pc
  );

  modport slave (
    output exc_valid, exc_cause, exc_tval, trap_pc, flush_ack, redirect_ready,
    input  exc_ack, flush_req, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_entry_ctrl.sv
// Machine trap-state owner: arbitrates exceptions/interrupts/MRET, updates mepc/mcause/mtval/mstatus,
// then sequences pipeline flush and fetch redirect.
module trap_entry_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  trap_entry_if.master      bus,
  input  logic              irq_sample,
  input  logic              irq_meip,
  input  logic              irq_msip,
  input  logic              irq_mtip,
  input  logic [2:0]        irq_en,
  input  logic [31:0]       mtvec,
  input  logic              mret_pulse,
  input  logic              csr_mstatus_we,
  input  logic [3:0]        csr_mstatus_wdata,
  output logic [1:0]        priv,
  output logic              mstatus_mie,
  output logic              mstatus_mpie,
  output logic [1:0]        mstatus_mpp,
  output logic [31:0]       mepc,
  output logic [31:0]       mtval,
  output logic [31:0]       mcause,
  output logic              busy
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  priv_q, mpp_q;
  logic        mie_q, mpie_q;
  logic [31:0] mepc_q, mcause_q, mtval_q, redirect_pc_q;
  logic        exc_ack_q;

  logic        idle;
  logic        irq_ok;
  logic [2:0]  irq_pend;
  logic        irq_any;
  logic [3:0]  irq_code;
  logic        take_exc, take_irq, take_trap, take_mret;
  logic [3:0]  trap_code;

  // Only U and M exist, so any other MPP encoding collapses to U.
  function automatic logic [1:0] legal_mpp(input logic [1:0] mpp_in);
    return (mpp_in == PRIV_M) ? PRIV_M : PRIV_U;
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic is_irq,
                                              input logic [3:0] code);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (VECTORED_EN && (tvec[1:0] == 2'b01) && is_irq)
      return base + {26'b0, code, 2'b00};
    return base;
  endfunction

  // Arbitration: exception, then enabled interrupt, then MRET; only evaluated in IDLE.
  always_comb begin
    idle      = (state_q == IDLE);
    irq_ok    = irq_sample && ((priv_q != PRIV_M) || mie_q);
    irq_pend  = {irq_meip & irq_en[2], irq_msip & irq_en[1], irq_mtip & irq_en[0]};
    irq_any   = |irq_pend;
    irq_code  = 4'd7;
    if (irq_pend[2])      irq_code = 4'd11;
    else if (irq_pend[1]) irq_code = 4'd3;
    take_exc  = idle && bus.exc_valid;
    take_irq  = idle && !bus.exc_valid && irq_ok && irq_any;
    take_trap = take_exc || take_irq;
    take_mret = idle && !take_trap && mret_pulse;
    trap_code = take_exc ? bus.exc_cause : irq_code;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_trap)      state_d = FLUSH;
        else if (take_mret) state_d = REDIRECT;
      end
      FLUSH:    if (bus.flush_ack)      state_d = REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Architectural trap state; trap/MRET updates take precedence over a same-cycle CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      priv_q        <= PRIV_M;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= PRIV_M;
      mepc_q        <= RESET_PC;
      mcause_q      <= 32'h0;
      mtval_q       <= 32'h0;
      redirect_pc_q <= 32'h0;
      exc_ack_q     <= 1'b0;
    end else begin
      exc_ack_q <= take_exc;
      if (take_trap) begin
        mepc_q        <= bus.trap_pc & ~32'h3;
        mcause_q      <= {take_irq, 27'b0, trap_code};
        mtval_q       <= take_exc ? bus.exc_tval : 32'h0;
        mpie_q        <= mie_q;
        mie_q         <= 1'b0;
        mpp_q         <= priv_q;
        priv_q        <= PRIV_M;
        redirect_pc_q <= trap_target(mtvec, take_irq, trap_code);
      end else if (take_mret) begin
        mie_q         <= mpie_q;
        mpie_q        <= 1'b1;
        priv_q        <= mpp_q;
        mpp_q         <= PRIV_U;
        redirect_pc_q <= mepc_q;
      end else if (idle && csr_mstatus_we) begin
        mie_q  <= csr_mstatus_wdata[0];
        mpie_q <= csr_mstatus_wdata[1];
        mpp_q  <= legal_mpp(csr_mstatus_wdata[3:2]);
      end
    end
  end

  always_comb begin
    bus.flush_req      = (state_q == FLUSH);
    bus.redirect_valid = (state_q == REDIRECT);
    bus.redirect_pc    = redirect_pc_q;
    bus.exc_ack        = exc_ack_q;
    busy               = (state_q != IDLE);
    priv               = priv_q;
    mstatus_mie        = mie_q;
    mstatus_mpie       = mpie_q;
    mstatus_mpp        = mpp_q;
    mepc               = mepc_q;
    mtval              = mtval_q;
    mcause             = mcause_q;
  end

endmodule
